// File: rtl/agc_io_pkg.sv
// Shared definitions for the AGC IO channel responders.
// Holds the channel map, the 15-bit word type and the status/control bit
// positions used by both the decoder and the bench-facing interface.
package agc_io_pkg;

  typedef logic [14:0] word15_t;

  typedef enum logic [2:0] {
    CH_KEYIN   = 3'd0,
    CH_KEYSTAT = 3'd1,
    CH_DSPOUT  = 3'd2,
    CH_LAMPS   = 3'd3,
    CH_TIMER   = 3'd4,
    CH_KEYCTL  = 3'd5
  } chan_e;

  localparam int KEY_W = 5;

  // KEYIN / KEYSTAT status bits
  localparam int ST_NOT_EMPTY = 14;
  localparam int ST_OVERFLOW  = 14;
  localparam int ST_OVERRUN   = 13;

  // KEYCTL write bits
  localparam int KC_CLR_FIFO = 0;
  localparam int KC_CLR_OVF  = 1;
  localparam int KC_CLR_OVR  = 2;

endpackage

// File: rtl/agc_dsky_port_if.sv
// IO channel bus between the core (master) and a channel responder (slave).
// Ports: read select/strobe and combinational read data; write select,
// strobe and data. Names follow the core's IO bus.
interface agc_dsky_port_if;
  import agc_io_pkg::*;

  logic [2:0] IO_read_sel;
  logic       IO_read_en;
  word15_t    IO_read_data;
  logic [2:0] IO_write_sel;
  logic       IO_write_en;
  word15_t    IO_write_data;

  modport master (
    output IO_read_sel, IO_read_en, IO_write_sel, IO_write_en, IO_write_data,
    input  IO_read_data
  );

  modport slave (
    input  IO_read_sel, IO_read_en, IO_write_sel, IO_write_en, IO_write_data,
    output IO_read_data
  );

endinterface

// File: rtl/agc_key_fifo.sv
// Synchronous keystroke FIFO; head/count/full/empty reflect registered state.
// Ports: push/din, pop, clear (wins over push and pop), head, count, full, empty.
// A push while full is accepted only if a pop happens in the same cycle.
module agc_key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_pop   = pop & ~empty;
    // A full FIFO still takes a push when a pop frees a slot this cycle.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/agc_dsky_port.sv
// DSKY IO channel responder: keystroke FIFO, display word, lamps, timer.
// Ports: clock/reset, IO bus (slave modport, combinational read data),
// keyboard strobe/code, display valid/ready/data, lamps, timer_irq.
module agc_dsky_port
  import agc_io_pkg::*;
#(
  parameter int KEY_DEPTH = 8,
  parameter int TICK_DIV  = 100
) (
  input  logic               clock,
  input  logic               reset,
  agc_dsky_port_if.slave     io,
  input  logic               key_strobe,
  input  logic [KEY_W-1:0]   key_code,
  output logic               disp_valid,
  output word15_t            disp_data,
  input  logic               disp_ready,
  output word15_t            lamps,
  output logic               timer_irq
);

  localparam int KAW = $clog2(KEY_DEPTH);
  localparam int PW  = $clog2(TICK_DIV);

  logic             overflow_q, overflow_d;
  logic             overrun_q, overrun_d;
  logic             disp_valid_q, disp_valid_d;
  word15_t          disp_data_q, disp_data_d;
  word15_t          lamps_q, lamps_d;
  word15_t          timer_q, timer_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             timer_irq_q, timer_irq_d;

  logic             wr_dspout, wr_lamps, wr_timer, wr_keyctl;
  logic             rd_pop, clr_fifo, handshake, presc_wrap;
  logic [KEY_W-1:0] key_head;
  logic [KAW:0]     key_count;
  logic             key_full, key_empty;
  word15_t          rd_data;

  assign wr_dspout  = io.IO_write_en && (io.IO_write_sel == CH_DSPOUT);
  assign wr_lamps   = io.IO_write_en && (io.IO_write_sel == CH_LAMPS);
  assign wr_timer   = io.IO_write_en && (io.IO_write_sel == CH_TIMER);
  assign wr_keyctl  = io.IO_write_en && (io.IO_write_sel == CH_KEYCTL);
  assign rd_pop     = io.IO_read_en && (io.IO_read_sel == CH_KEYIN);
  assign clr_fifo   = wr_keyctl && io.IO_write_data[KC_CLR_FIFO];
  assign handshake  = disp_valid_q && disp_ready;
  assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));

  agc_key_fifo #(
    .DEPTH (KEY_DEPTH),
    .WIDTH (KEY_W)
  ) u_key_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (key_strobe),
    .din   (key_code),
    .pop   (rd_pop),
    .clear (clr_fifo),
    .head  (key_head),
    .count (key_count),
    .full  (key_full),
    .empty (key_empty)
  );

  always_comb begin
    overflow_d   = overflow_q;
    overrun_d    = overrun_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    lamps_d      = lamps_q;
    timer_d      = timer_q;
    presc_d      = presc_q;
    timer_irq_d  = 1'b0;

    // Sticky flags: a clear request and a new event in the same cycle
    // leave the flag set, so no event is ever lost.
    if (wr_keyctl && io.IO_write_data[KC_CLR_OVF]) overflow_d = 1'b0;
    if (wr_keyctl && io.IO_write_data[KC_CLR_OVR]) overrun_d  = 1'b0;

    // A full FIFO is never empty, so rd_pop alone means a real pop here.
    if (key_strobe && key_full && !rd_pop && !clr_fifo) overflow_d = 1'b1;

    if (wr_dspout) begin
      disp_data_d  = io.IO_write_data;
      disp_valid_d = 1'b1;
      if (disp_valid_q && !handshake) overrun_d = 1'b1;
    end else if (handshake) begin
      disp_valid_d = 1'b0;
    end

    if (wr_lamps) lamps_d = io.IO_write_data;

    // A load takes priority over a coincident tick and restarts prescaling.
    if (wr_timer) begin
      timer_d = io.IO_write_data;
      presc_d = '0;
    end else if (presc_wrap) begin
      presc_d     = '0;
      timer_d     = timer_q + 15'd1;
      timer_irq_d = (timer_q == '1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      overrun_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      lamps_q      <= '0;
      timer_q      <= '0;
      presc_q      <= '0;
      timer_irq_q  <= 1'b0;
    end else begin
      overflow_q   <= overflow_d;
      overrun_q    <= overrun_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      lamps_q      <= lamps_d;
      timer_q      <= timer_d;
      presc_q      <= presc_d;
      timer_irq_q  <= timer_irq_d;
    end
  end

  // Read mux reflects registered state, so a same-cycle write is not visible.
  always_comb begin
    rd_data = '0;
    case (io.IO_read_sel)
      CH_KEYIN: begin
        if (!key_empty) begin
          rd_data[ST_NOT_EMPTY] = 1'b1;
          rd_data[KEY_W-1:0]    = key_head;
        end
      end
      CH_KEYSTAT: begin
        rd_data[ST_OVERFLOW] = overflow_q;
        rd_data[ST_OVERRUN]  = overrun_q;
        rd_data[4:0]         = 5'(key_count);
      end
      CH_DSPOUT: rd_data[0] = disp_valid_q;
      CH_LAMPS:  rd_data    = lamps_q;
      CH_TIMER:  rd_data    = timer_q;
      default:   rd_data    = '0;
    endcase
  end

  assign io.IO_read_data = rd_data;
  assign disp_valid      = disp_valid_q;
  assign disp_data       = disp_data_q;
  assign lamps           = lamps_q;
  assign timer_irq       = timer_irq_q;

endmodule

// File: tb/tb_agc_dsky_port.sv
// Bench for agc_dsky_port: directed scenarios plus a randomized run checked
// against a queue/arithmetic reference model updated on every rising edge.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_agc_dsky_port;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_strobe = 1'b0;
  logic [4:0]  key_code = '0;
  logic        disp_valid;
  logic [14:0] disp_data;
  logic        disp_ready = 1'b0;
  logic [14:0] lamps;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  agc_dsky_port_if io();

  agc_dsky_port #(.KEY_DEPTH(DEPTH), .TICK_DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .io         (io),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready),
    .lamps      (lamps),
    .timer_irq  (timer_irq)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [4:0]  q[$];
  bit          m_ovf, m_ovr, m_dv, m_irq;
  logic [14:0] m_dd, m_lamps, m_tbase;
  int          m_ticks;
  bit          mk_ctl, mk_dw, mk_pop, mk_full, mk_hs;

  function automatic logic [14:0] timer_now();
    return m_tbase + 15'(m_ticks / DIV);
  endfunction

  function automatic logic [14:0] exp_rd(input logic [2:0] s);
    logic [14:0] r;
    r = '0;
    case (s)
      3'd0: if (q.size() > 0) r = 15'h4000 | 15'(q[0]);
      3'd1: r = {m_ovf, m_ovr, 8'd0, 5'(q.size())};
      3'd2: r = {14'd0, m_dv};
      3'd3: r = m_lamps;
      3'd4: r = timer_now();
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_ovf = 0; m_ovr = 0; m_dv = 0; m_irq = 0;
      m_dd = '0; m_lamps = '0; m_tbase = '0; m_ticks = 0;
    end else begin
      mk_ctl = io.IO_write_en && io.IO_write_sel == 3'd5;
      mk_dw  = io.IO_write_en && io.IO_write_sel == 3'd2;
      mk_pop = io.IO_read_en && io.IO_read_sel == 3'd0 && q.size() > 0;
      mk_hs  = m_dv && disp_ready;
      if (mk_ctl && io.IO_write_data[1]) m_ovf = 0;
      if (mk_ctl && io.IO_write_data[2]) m_ovr = 0;
      if (mk_ctl && io.IO_write_data[0]) q.delete();
      else begin
        mk_full = (q.size() == DEPTH);
        if (mk_pop) void'(q.pop_front());
        if (key_strobe) begin
          if (mk_full && !mk_pop) m_ovf = 1;
          else q.push_back(key_code);
        end
      end
      if (mk_dw) begin
        if (m_dv && !mk_hs) m_ovr = 1;
        m_dd = io.IO_write_data;
        m_dv = 1;
      end else if (mk_hs) m_dv = 0;
      if (io.IO_write_en && io.IO_write_sel == 3'd3) m_lamps = io.IO_write_data;
      if (io.IO_write_en && io.IO_write_sel == 3'd4) begin
        m_tbase = io.IO_write_data; m_ticks = 0; m_irq = 0;
      end else begin
        m_ticks++;
        m_irq = (m_ticks % DIV == 0) && (timer_now() == 15'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    io.IO_read_sel = 3'd0; io.IO_read_en = 1'b0;
    io.IO_write_sel = 3'd0; io.IO_write_en = 1'b0; io.IO_write_data = '0;
    key_strobe = 1'b0; key_code = '0; disp_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] s, input logic [14:0] d);
    io.IO_write_sel = s; io.IO_write_en = 1'b1; io.IO_write_data = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); reset = 1'b1; step(); reset = 1'b0;
    io.IO_read_sel = 3'd4; #1;
    checks++; if (io.IO_read_data !== 15'd0) begin errors++; $display("FAIL rst_ch4 got %h want 0", io.IO_read_data); end
    checks++; if ({disp_valid, disp_data, lamps, timer_irq} !== 32'd0) begin errors++; $display("FAIL rst_outs got dv=%b dd=%h l=%h irq=%b want 0", disp_valid, disp_data, lamps, timer_irq); end
    for (int s = 0; s < 8; s++) begin
      if (s == 4) continue;
      io.IO_read_sel = 3'(s); #1;
      checks++; if (io.IO_read_data !== 15'd0) begin errors++; $display("FAIL rst_ch%0d got %h want 0", s, io.IO_read_data); end
      step();
    end
  endtask

  task automatic test_keys();
    idle();
    key_strobe = 1; key_code = 5'h11; step();
    key_code = 5'h02; step();
    key_strobe = 0; io.IO_read_sel = 3'd1; #1;
    checks++; if (io.IO_read_data !== 15'h0002) begin errors++; $display("FAIL keys_count got %h want 0002", io.IO_read_data); end
    io.IO_read_sel = 3'd0; io.IO_read_en = 1; #1;
    checks++; if (io.IO_read_data !== 15'h4011) begin errors++; $display("FAIL keys_pop1 got %h want 4011", io.IO_read_data); end
    step(); #1;
    checks++; if (io.IO_read_data !== 15'h4002) begin errors++; $display("FAIL keys_pop2 got %h want 4002", io.IO_read_data); end
    step(); io.IO_read_en = 0; #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL keys_empty got %h want 0", io.IO_read_data); end
    io.IO_read_sel = 3'd1; #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL keys_count0 got %h want 0", io.IO_read_data); end
  endtask

  task automatic test_overflow();
    logic [4:0] keys[8];
    logic [4:0] order[8];
    logic [4:0] nk;
    idle();
    for (int i = 0; i < 8; i++) begin
      keys[i] = 5'($urandom_range(0, 30));
      key_strobe = 1; key_code = keys[i]; step();
    end
    key_code = 5'h1F; step();
    key_strobe = 0; io.IO_read_sel = 3'd1; #1;
    checks++; if (io.IO_read_data !== 15'h4008) begin errors++; $display("FAIL ovf_set got %h want 4008", io.IO_read_data); end
    wr(3'd5, 15'h0002); step(); io.IO_write_en = 0; #1;
    checks++; if (io.IO_read_data !== 15'h0008) begin errors++; $display("FAIL ovf_clr got %h want 0008", io.IO_read_data); end
    nk = 5'($urandom_range(0, 30));
    key_strobe = 1; key_code = nk; io.IO_read_sel = 3'd0; io.IO_read_en = 1; #1;
    checks++; if (io.IO_read_data !== (15'h4000 | 15'(keys[0]))) begin errors++; $display("FAIL full_pushpop_head got %h want %h", io.IO_read_data, 15'h4000 | 15'(keys[0])); end
    step(); key_strobe = 0; io.IO_read_en = 0; io.IO_read_sel = 3'd1; #1;
    checks++; if (io.IO_read_data !== 15'h0008) begin errors++; $display("FAIL full_pushpop_cnt got %h want 0008", io.IO_read_data); end
    for (int i = 0; i < 7; i++) order[i] = keys[i+1];
    order[7] = nk;
    io.IO_read_sel = 3'd0; io.IO_read_en = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (io.IO_read_data !== (15'h4000 | 15'(order[i]))) begin errors++; $display("FAIL drain%0d got %h want %h", i, io.IO_read_data, 15'h4000 | 15'(order[i])); end
      step();
    end
    io.IO_read_en = 0;
  endtask

  task automatic test_display();
    idle();
    wr(3'd2, 15'h1234); step(); io.IO_write_en = 0; io.IO_read_sel = 3'd2; #1;
    checks++; if (disp_valid !== 1'b1 || disp_data !== 15'h1234) begin errors++; $display("FAIL disp_load got dv=%b dd=%h want 1 1234", disp_valid, disp_data); end
    checks++; if (io.IO_read_data !== 15'h0001) begin errors++; $display("FAIL disp_rd got %h want 0001", io.IO_read_data); end
    wr(3'd2, 15'h0ABC); step(); io.IO_write_en = 0; io.IO_read_sel = 3'd1; #1;
    checks++; if (disp_data !== 15'h0ABC) begin errors++; $display("FAIL disp_over got %h want 0abc", disp_data); end
    checks++; if (io.IO_read_data !== 15'h2000) begin errors++; $display("FAIL overrun_set got %h want 2000", io.IO_read_data); end
    disp_ready = 1; step(); disp_ready = 0; #1;
    checks++; if (disp_valid !== 1'b0 || disp_data !== 15'h0ABC) begin errors++; $display("FAIL disp_hs got dv=%b dd=%h want 0 0abc", disp_valid, disp_data); end
    wr(3'd2, 15'h0555); step();
    wr(3'd5, 15'h0004); step();
    wr(3'd2, 15'h0666); disp_ready = 1; step(); io.IO_write_en = 0; disp_ready = 0; #1;
    checks++; if (disp_valid !== 1'b1 || disp_data !== 15'h0666) begin errors++; $display("FAIL disp_hs_wr got dv=%b dd=%h want 1 0666", disp_valid, disp_data); end
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL hs_wr_no_overrun got %h want 0", io.IO_read_data); end
    disp_ready = 1; step(); disp_ready = 0;
  endtask

  task automatic test_timer();
    idle();
    wr(3'd4, 15'h7FFE); step(); io.IO_write_en = 0; io.IO_read_sel = 3'd4;
    repeat (4) step();
    #1;
    checks++; if (io.IO_read_data !== 15'h7FFF || timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_7fff got %h irq=%b want 7fff 0", io.IO_read_data, timer_irq); end
    repeat (3) step();
    #1;
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_early_irq got %b want 0", timer_irq); end
    step(); #1;
    checks++; if (io.IO_read_data !== 15'h0000 || timer_irq !== 1'b1) begin errors++; $display("FAIL tmr_wrap got %h irq=%b want 0 1", io.IO_read_data, timer_irq); end
    step(); #1;
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_irq_len got %b want 0", timer_irq); end
    wr(3'd4, 15'h7FFF); step(); io.IO_write_en = 0;
    repeat (3) step();
    wr(3'd4, 15'h1234); step(); io.IO_write_en = 0; #1;
    checks++; if (io.IO_read_data !== 15'h1234 || timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_ld_at_wrap got %h irq=%b want 1234 0", io.IO_read_data, timer_irq); end
  endtask

  task automatic test_same_cycle();
    idle();
    io.IO_read_sel = 3'd3; wr(3'd3, 15'h00F0); #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL lamps_rdw got %h want 0", io.IO_read_data); end
    step(); io.IO_write_en = 0; #1;
    checks++; if (lamps !== 15'h00F0 || io.IO_read_data !== 15'h00F0) begin errors++; $display("FAIL lamps_ld got %h/%h want 00f0", lamps, io.IO_read_data); end
    key_strobe = 1; key_code = 5'h03; step(); key_code = 5'h04; step();
    wr(3'd5, 15'h0001); key_code = 5'h05; io.IO_read_sel = 3'd0; io.IO_read_en = 1; step();
    idle(); io.IO_read_sel = 3'd1; #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL clr_cnt got %h want 0", io.IO_read_data); end
    io.IO_read_sel = 3'd0; #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL clr_head got %h want 0", io.IO_read_data); end
  endtask

  task automatic test_reset_mid();
    idle();
    key_strobe = 1;
    for (int i = 0; i < 3; i++) begin key_code = 5'(i + 7); step(); end
    key_strobe = 0; wr(3'd2, 15'h0777); step();
    wr(3'd3, 15'h05A5); step(); io.IO_write_en = 0;
    step(); step();
    io.IO_read_sel = 3'd1; #1;
    checks++; if (io.IO_read_data !== 15'h0003 || disp_valid !== 1'b1) begin errors++; $display("FAIL pre_rst got %h dv=%b want 0003 1", io.IO_read_data, disp_valid); end
    reset = 1; step(); reset = 0; #1;
    checks++; if ({disp_valid, disp_data, lamps, timer_irq} !== 32'd0) begin errors++; $display("FAIL mid_rst_outs got dv=%b dd=%h l=%h irq=%b want 0", disp_valid, disp_data, lamps, timer_irq); end
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL mid_rst_ch1 got %h want 0", io.IO_read_data); end
    io.IO_read_sel = 3'd6; #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL mid_rst_ch6 got %h want 0", io.IO_read_data); end
    io.IO_read_sel = 3'd7; #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL mid_rst_ch7 got %h want 0", io.IO_read_data); end
    io.IO_read_sel = 3'd4; #1;
    checks++; if (io.IO_read_data !== 15'h0000) begin errors++; $display("FAIL mid_rst_ch4 got %h want 0", io.IO_read_data); end
  endtask

  task automatic test_random();
    logic [14:0] e;
    for (int n = 0; n < 600; n++) begin
      io.IO_read_sel  = 3'($urandom_range(0, 7));
      io.IO_read_en   = ($urandom_range(0, 9) < 4);
      io.IO_write_sel = 3'($urandom_range(0, 7));
      io.IO_write_en  = ($urandom_range(0, 9) < 3);
      if (io.IO_write_sel == 3'd4 && $urandom_range(0, 1) == 1)
        io.IO_write_data = 15'h7FFC + 15'($urandom_range(0, 3));
      else if (io.IO_write_sel == 3'd5 && $urandom_range(0, 3) != 0)
        io.IO_write_data = 15'($urandom_range(0, 7)) & 15'h0006;
      else
        io.IO_write_data = 15'($urandom);
      key_strobe = ($urandom_range(0, 1) == 1);
      key_code   = 5'($urandom);
      disp_ready = ($urandom_range(0, 2) == 0);
      #1;
      e = exp_rd(io.IO_read_sel);
      checks++; if (io.IO_read_data !== e) begin errors++; $display("FAIL rnd_rd%0d ch%0d got %h want %h", n, io.IO_read_sel, io.IO_read_data, e); end
      checks++; if (disp_valid !== m_dv || disp_data !== m_dd) begin errors++; $display("FAIL rnd_disp%0d got %b/%h want %b/%h", n, disp_valid, disp_data, m_dv, m_dd); end
      checks++; if (lamps !== m_lamps || timer_irq !== m_irq) begin errors++; $display("FAIL rnd_lamp_irq%0d got %h/%b want %h/%b", n, lamps, timer_irq, m_lamps, m_irq); end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    @(negedge clock);
    test_reset();
    test_keys();
    test_overflow();
    test_display();
    test_timer();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/agc_dsky_port.md
Name: agc_dsky_port

Overview:
- Responder on the core's IO channel bus. The core initiates reads and writes via IO_read_sel, IO_write_sel, IO_write_data and IO_write_en; this block decodes them and returns IO_read_data.
- Peripheral side: a keystroke FIFO fed by a strobe-only keyboard, a display word with a valid/ready handshake, a lamp register, and a prescaled 15-bit timer.
- Sits beside Core in the top level, in place of a bare IO stub.

Parameters:
- KEY_DEPTH, 8, keystroke FIFO depth; power of 2, range 2..16.
- TICK_DIV, 100, clock cycles per timer increment; must be >= 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- IO_read_sel  in  3  channel selected for read
- IO_read_en  in  1  read strobe; enables read side effects (FIFO pop)
- IO_read_data  out  15  combinational read data for IO_read_sel
- IO_write_sel  in  3  channel selected for write
- IO_write_en  in  1  write strobe
- IO_write_data  in  15  write data
- key_strobe  in  1  one-cycle keypress pulse; no backpressure
- key_code  in  5  keycode, sampled when key_strobe=1
- disp_valid  out  1  display word pending
- disp_data  out  15  display word
- disp_ready  in  1  display accepts the word when disp_valid & disp_ready
- lamps  out  15  lamp register
- timer_irq  out  1  one-cycle pulse on timer wrap

Behaviour:
- Reset: FIFO empty, overflow=0, overrun=0, disp_valid=0, disp_data=0, lamps=0, timer=0, prescaler=0, timer_irq=0. IO_read_data is therefore all-zero for every channel except ch0, which reads 0 when empty.
- Read path is combinational (0-cycle). When a channel is read and written in the same cycle, the read returns the pre-write value.
- Channel map:
  - ch0 KEYIN: read gives {bit14 = not empty, bits4:0 = FIFO head, others 0}. IO_read_en with not empty pops one entry at the clock edge. A pop while empty is a no-op. Writes are ignored.
  - ch1 KEYSTAT: read gives {bit14 = overflow, bit13 = overrun, bits4:0 = FIFO count}. Writes are ignored.
  - ch2 DSPOUT: a write loads disp_data and sets disp_valid=1. If disp_valid=1 and no handshake occurs that cycle, the write overwrites disp_data and sets overrun. A handshake in the same cycle as a write leaves disp_valid=1 carrying the new word. Handshake alone: disp_valid=0 next cycle; disp_data holds. Read gives {bit0 = disp_valid}.
  - ch3 LAMPS: write loads lamps; read returns lamps.
  - ch4 TIMER: read returns timer. A write loads timer and clears the prescaler; timer_irq is not pulsed on a load.
  - ch5 KEYCTL: write bit0 = clear FIFO, bit1 = clear overflow, bit2 = clear overrun. Read returns 0.
  - ch6, ch7: read 0, writes ignored.
- FIFO:
  - key_strobe while not full: push key_code.
  - Full with no pop in the same cycle: drop the key and set overflow (sticky).
  - Full with a simultaneous pop: both happen and count is unchanged.
  - Empty with a simultaneous push and pop: pop is a no-op and the push happens.
  - ch5 clear-FIFO in the same cycle as key_strobe and/or pop: clear wins, strobe discarded, FIFO empty next cycle.
- Timer:
  - Prescaler counts 0..TICK_DIV-1. On its wrap, timer increments by 1.
  - Timer 15'h7FFF -> 0 on increment, with timer_irq=1 for exactly that one cycle.
  - A write to ch4 in the same cycle as a prescaler wrap takes the written value; no increment, no irq.
- Reset asserted mid-operation (pending display, partial prescale, non-empty FIFO) returns everything to reset values on the next edge. Pending display words and keys are discarded.

Decomposition:
- Shared package agc_io_pkg holds:
  - channel enum: CH_KEYIN=0, CH_KEYSTAT=1, CH_DSPOUT=2, CH_LAMPS=3, CH_TIMER=4, CH_KEYCTL=5;
  - typedef word15_t;
  - status bit positions (ST_OVERFLOW=14, ST_OVERRUN=13, KEYCTL bit indices).
- One sub-module, agc_key_fifo: parameterised synchronous FIFO with push, pop, clear, head, count, full, empty. The top-level handles decode, display, lamps and timer.

Test Plan:
- Reset, then strobe keycodes 5'h11, 5'h02 -> ch1 reads count=2. A ch0 read with IO_read_en returns 15'h4011, then 15'h4002; afterwards ch0 reads 0 and count=0.
- Fill FIFO with 8 keys, strobe a 9th (5'h1F) -> overflow bit14 set in ch1, count=8, 9th key absent. ch5 write 15'h0002 -> overflow clears. Full FIFO with simultaneous push and pop -> count stays 8 and the FIFO order is preserved.
- ch2 write 15'h1234 with disp_ready=0 -> disp_valid=1, disp_data=15'h1234. Write 15'h0ABC before the handshake -> disp_data=15'h0ABC and overrun bit13 set. Raise disp_ready -> disp_valid=0 the next cycle.
- TICK_DIV=4; ch4 write 15'h7FFE -> after 4 cycles timer=15'h7FFF; after 4 more cycles timer=0 with timer_irq high for exactly 1 cycle.
- Same cycle: ch3 write 15'h00F0 while reading ch3 -> read returns old value 0; next cycle lamps=15'h00F0. ch5 clear-FIFO coincident with key_strobe -> FIFO empty.
- With the FIFO holding 3 keys and disp_valid=1, assert reset for 1 cycle -> all outputs at reset values, ch1 reads 0, ch6/ch7 read 0.
